regfile_mp: RTL and testbench

// - Parametrised multi-port integer register file; successor to the single-write, dual-read file.
// - Configurable read ports, write ports, width, depth and same-cycle write->read bypass.
// - Adds a sequential clear engine: zeroes the array after reset or on request, with a busy flag.
// - Sits between decode (read ports) and WB/extra retire lanes (write ports) of the RISC-V core.

---
 rtl/regfile_mp_pkg.sv | 17 +
 rtl/regfile_mp_clear_fsm.sv | 60 ++++++
 rtl/regfile_mp.sv | 94 +++++++++
 tb/tb_regfile_mp.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package regfile_mp_pkg;

    localparam int unsigned RF_XLEN   = 32;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_AW    = $clog2(REG_COUNT);

    typedef logic [RF_XLEN-1:0] xlen_t;
    typedef logic [REG_AW-1:0]  reg_addr_t;

    // Clear engine state: CLEAR sweeps the array, READY serves normal traffic.
    typedef enum logic [0:0] {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_clear_fsm.sv
// Sequential clear engine: zeroes entries 1..NREGS-1, one per cycle, after reset or on request.
module regfile_mp_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter int unsigned NREGS = REG_COUNT,
    localparam int unsigned AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] FIRST_PTR = AW'(1);
    localparam logic [AW-1:0] LAST_PTR  = AW'(NREGS - 1);

    rf_state_e     state;
    logic [AW-1:0] clr_ptr;

    // State, sweep pointer and registered busy flag; clr_req is ignored while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_ptr <= FIRST_PTR;
            busy    <= 1'b1;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (clr_ptr == LAST_PTR) begin
                        state   <= RF_READY;
                        busy    <= 1'b0;
                        clr_ptr <= FIRST_PTR;
                    end else begin
                        clr_ptr <= clr_ptr + AW'(1);
                    end
                end
                RF_READY: begin
                    if (clr_req) begin
                        state   <= RF_CLEAR;
                        busy    <= 1'b1;
                        clr_ptr <= FIRST_PTR;
                    end
                end
                default: begin
                    state   <= RF_CLEAR;
                    busy    <= 1'b1;
                    clr_ptr <= FIRST_PTR;
                end
            endcase
        end
    end

    assign ready    = (state == RF_READY);
    assign clr_we   = (state == RF_CLEAR);
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional same-cycle write->read bypass and a clear engine.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN   = RF_XLEN,
    parameter int unsigned NREGS  = REG_COUNT,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_req,
    output logic                         busy,
    input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]  rd_data,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data
);

    // Reject unsupported configurations at elaboration.
    if (NREGS < 4 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("regfile_mp: NREGS must be a power of two and at least 4");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
        $error("regfile_mp: NUM_WR must be in 1..2");
    end

    logic          ready;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    regfile_mp_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Entry 0 is never written and never read; it reads as zero through the read mux.
    logic [XLEN-1:0] regs [NREGS];

    // Array update: clear sweep in CLEAR, port writes in READY (the two never overlap).
    // Ports are visited in ascending order so the highest index wins on an address clash.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_addr] <= '0;
        end else if (ready) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (we[i] && (wr_addr[i] != '0)) begin
                    regs[wr_addr[i]] <= wr_data[i];
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;

        if (BYPASS) begin : g_byp
            // Forward this cycle's write data; last matching port wins, like the array.
            always_comb begin
                byp_hit  = 1'b0;
                byp_data = '0;
                for (int i = 0; i < NUM_WR; i++) begin
                    if (ready && we[i] && (wr_addr[i] == rd_addr[j])) begin
                        byp_hit  = 1'b1;
                        byp_data = wr_data[i];
                    end
                end
            end
        end else begin : g_no_byp
            assign byp_hit  = 1'b0;
            assign byp_data = '0;
        end

        // Address 0 and any read while clearing return zero, so no stale or X data escapes.
        assign rd_data[j] = (busy || (rd_addr[j] == '0)) ? '0
                          : byp_hit                      ? byp_data
                          :                                regs[rd_addr[j]];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypass and a non-bypass instance share all inputs.
module tb_regfile_mp;

    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr_req = 1'b0;
    logic [1:0][AW-1:0]   rd_addr = '0;
    logic [1:0]           we = '0;
    logic [1:0][AW-1:0]   wr_addr = '0;
    logic [1:0][31:0]     wr_data = '0;
    logic                 busy_b, busy_n;
    logic [1:0][31:0]     rd_b, rd_n;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural contents plus remaining clear cycles.
    logic [31:0] mem [NR];
    int          clr_left = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(32), .NREGS(NR), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)
    ) u_byp (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b),
        .rd_addr(rd_addr), .rd_data(rd_b), .we(we), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    regfile_mp #(
        .XLEN(32), .NREGS(NR), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b0)
    ) u_nob (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_n),
        .rd_addr(rd_addr), .rd_data(rd_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // A clear leaves every entry zero after NR-1 cycles, whatever was written around it.
    task automatic start_clear();
        for (int a = 0; a < NR; a++) mem[a] = '0;
        clr_left = NR - 1;
    endtask

    // Apply the effect of the coming clock edge to the model, then advance past it.
    task automatic tick();
        if (rst_n) begin
            if (clr_left > 0) begin
                clr_left--;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (we[i] && wr_addr[i] != 0) mem[wr_addr[i]] = wr_data[i];
                end
                if (clr_req) start_clear();
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rd(int j, bit byp);
        logic [31:0] v;
        if (clr_left > 0 || rd_addr[j] == 0) return 32'h0;
        v = mem[rd_addr[j]];
        if (byp) begin
            for (int i = 0; i < 2; i++) begin
                if (we[i] && wr_addr[i] == rd_addr[j]) v = wr_data[i];
            end
        end
        return v;
    endfunction

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        #12;
        start_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (busy_b !== 1'b1 || busy_n !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy: got %b/%b want 1/1", busy_b, busy_n);
        end
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n != NR - 1 || busy_n !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy_len: got %0d cycles (busy_n=%b) want %0d", n, busy_n, NR - 1);
        end
        for (int a = 0; a < NR; a++) begin
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(NR - 1 - a);
            #1;
            total++;
            if (rd_b !== '0 || rd_n !== '0) begin
                bad++;
                $display("FAIL reset_read addr %0d: got %h/%h want 0", a, rd_b, rd_n);
            end
        end
    endtask

    task automatic test_bypass();
        rd_addr[0] = 5;
        rd_addr[1] = 6;
        we         = 2'b01;
        wr_addr[0] = 5;
        wr_data[0] = 32'hDEADBEEF;
        wr_addr[1] = 0;
        #1;
        total++;
        if (rd_b[0] !== 32'hDEADBEEF || rd_n[0] !== exp_rd(0, 1'b0)) begin
            bad++;
            $display("FAIL bypass_same_cycle: got %h/%h want deadbeef/%h",
                     rd_b[0], rd_n[0], exp_rd(0, 1'b0));
        end
        tick();
        we = '0;
        #1;
        total++;
        if (rd_b[0] !== 32'hDEADBEEF || rd_n[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bypass_next_cycle: got %h/%h want deadbeef", rd_b[0], rd_n[0]);
        end
    endtask

    task automatic test_dual_write();
        logic [31:0] old;
        rd_addr[0] = 7;
        rd_addr[1] = 7;
        we         = 2'b11;
        wr_addr[0] = 7;
        wr_addr[1] = 7;
        wr_data[0] = 32'h11;
        wr_data[1] = 32'h22;
        old        = mem[7];
        #1;
        total++;
        if (rd_b[0] !== 32'h22 || rd_b[1] !== 32'h22 || rd_n[0] !== old) begin
            bad++;
            $display("FAIL dual_write_bypass: got %h/%h/%h want 22/22/%h",
                     rd_b[0], rd_b[1], rd_n[0], old);
        end
        tick();
        we = '0;
        #1;
        total++;
        if (rd_b[0] !== 32'h22 || rd_n[1] !== 32'h22) begin
            bad++;
            $display("FAIL dual_write_stored: got %h/%h want 22", rd_b[0], rd_n[1]);
        end
    endtask

    task automatic test_zero_addr();
        rd_addr    = '0;
        we         = 2'b11;
        wr_addr    = '0;
        wr_data[0] = 32'hFFFFFFFF;
        wr_data[1] = 32'hFFFFFFFF;
        #1;
        total++;
        if (rd_b !== '0 || rd_n !== '0) begin
            bad++;
            $display("FAIL zero_addr_bypass: got %h/%h want 0", rd_b, rd_n);
        end
        tick();
        we = '0;
        #1;
        total++;
        if (rd_b !== '0 || rd_n !== '0) begin
            bad++;
            $display("FAIL zero_addr_stored: got %h/%h want 0", rd_b, rd_n);
        end
    endtask

    task automatic test_random(int cycles);
        int n;
        for (int c = 0; c < cycles; c++) begin
            we = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                wr_addr[i] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                wr_data[i] = $urandom;
            end
            for (int j = 0; j < 2; j++) begin
                rd_addr[j] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            end
            clr_req = ($urandom_range(0, 79) == 0);
            #1;
            total++;
            if (busy_b !== (clr_left > 0) || busy_n !== (clr_left > 0)) begin
                bad++;
                $display("FAIL rand_busy cycle %0d: got %b/%b want %0b",
                         c, busy_b, busy_n, clr_left > 0);
            end
            for (int j = 0; j < 2; j++) begin
                total++;
                if (rd_b[j] !== exp_rd(j, 1'b1) || rd_n[j] !== exp_rd(j, 1'b0)) begin
                    bad++;
                    $display("FAIL rand_read cycle %0d port %0d addr %0d: got %h/%h want %h/%h",
                             c, j, rd_addr[j], rd_b[j], rd_n[j], exp_rd(j, 1'b1),
                             exp_rd(j, 1'b0));
                end
            end
            tick();
        end
        clr_req = 1'b0;
        we      = '0;
        n = 0;
        while (clr_left > 0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_clear();
        int n;
        we = 2'b01;
        for (int a = 1; a < NR; a++) begin
            wr_addr[0] = AW'(a);
            wr_data[0] = 32'(a);
            tick();
        end
        we = '0;
        for (int a = 1; a < NR; a++) begin
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(a);
            #1;
            total++;
            if (rd_b[0] !== 32'(a) || rd_n[1] !== 32'(a)) begin
                bad++;
                $display("FAIL clear_preload addr %0d: got %h/%h want %h", a, rd_b[0], rd_n[1], a);
            end
        end
        clr_req = 1'b1;
        we      = 2'b11;
        wr_addr[0] = 3;
        wr_addr[1] = 9;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            we         = 2'($urandom);
            wr_addr[0] = AW'($urandom_range(1, NR - 1));
            wr_addr[1] = AW'($urandom_range(1, NR - 1));
            wr_data[0] = $urandom;
            wr_data[1] = $urandom;
            tick();
            n++;
        end
        we = '0;
        total++;
        if (n != NR - 1) begin
            bad++;
            $display("FAIL clear_busy_len: got %0d cycles want %0d", n, NR - 1);
        end
        for (int a = 0; a < NR; a++) begin
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(a);
            #1;
            total++;
            if (rd_b !== '0 || rd_n !== '0) begin
                bad++;
                $display("FAIL clear_read addr %0d: got %h/%h want 0", a, rd_b, rd_n);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        we         = 2'b01;
        wr_addr[0] = 12;
        wr_data[0] = 32'h12345678;
        tick();
        we      = '0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        total++;
        if (busy_b !== 1'b1) begin
            bad++;
            $display("FAIL midclear_busy: got %b want 1", busy_b);
        end
        #2;
        rst_n = 1'b0;
        start_clear();
        #1;
        total++;
        if (busy_b !== 1'b1 || busy_n !== 1'b1) begin
            bad++;
            $display("FAIL midclear_reset_busy: got %b/%b want 1/1", busy_b, busy_n);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n != NR - 1) begin
            bad++;
            $display("FAIL midclear_restart_len: got %0d cycles want %0d", n, NR - 1);
        end
        for (int a = 0; a < NR; a++) begin
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(NR - 1 - a);
            #1;
            total++;
            if (rd_b !== '0 || rd_n !== '0) begin
                bad++;
                $display("FAIL midclear_read addr %0d: got %h/%h want 0", a, rd_b, rd_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_zero_addr();
        test_random(400);
        test_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
